// File: rtl/period_detector.sv
// period_detector: recovers an oscillator's half-period (count_max) from edges on data[7],
// with lock indication and a no-edge timeout.
module period_detector #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       data,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, SYNC, MEASURE} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    state_t state, state_nx;
    logic [CNT_W-1:0] counter, counter_nx, period_nx, meas;
    logic lvl_q, edge_det, at_limit, valid_nx, locked_nx, timeout_nx;
    logic unused_bits;
    assign unused_bits = ^data[6:0];
    assign edge_det = data[7] != lvl_q;
    assign at_limit = counter == LIMIT;
    assign meas = counter - CNT_W'(1);
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        period_nx  = period_out;
        valid_nx   = 1'b0;
        locked_nx  = locked;
        timeout_nx = 1'b0;
        if (!enable) begin
            state_nx   = IDLE;
            counter_nx = '0;
            locked_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx   = SYNC;
                    counter_nx = '0;
                    locked_nx  = 1'b0;
                end
                SYNC: begin
                    state_nx   = edge_det ? MEASURE : SYNC;
                    counter_nx = edge_det ? CNT_W'(1) : at_limit ? '0 : counter + CNT_W'(1);
                    timeout_nx = !edge_det && at_limit;
                end
                MEASURE: begin
                    // an edge coinciding with the limit still counts as a measurement
                    if (edge_det) begin
                        period_nx  = meas;
                        valid_nx   = 1'b1;
                        locked_nx  = meas == period_out;
                        counter_nx = CNT_W'(1);
                    end else if (at_limit) begin
                        state_nx   = SYNC;
                        timeout_nx = 1'b1;
                        locked_nx  = 1'b0;
                        counter_nx = '0;
                    end else begin
                        counter_nx = counter + CNT_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            lvl_q        <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            counter      <= counter_nx;
            lvl_q        <= data[7];
            period_out   <= period_nx;
            period_valid <= valid_nx;
            locked       <= locked_nx;
            timeout      <= timeout_nx;
        end
    end
endmodule

// File: tb/tb_period_detector.sv
// tb_period_detector: table-driven edge intervals with a strobe/timeout scoreboard.
module tb_period_detector;
    localparam int CNT_W = 16;
    localparam int TMO   = 64;
    typedef struct {int n; logic strobe; logic [CNT_W-1:0] per; logic lck;} vec_t;
    typedef struct {int cyc; logic [CNT_W-1:0] per; logic lck;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, lvl = 1'b0;
    logic [7:0] data = 8'h00;
    logic [CNT_W-1:0] period_out;
    logic period_valid, locked, timeout;
    int cyc = 0, total = 0, bad = 0, tc = 0;
    exp_t sq[$], e;
    int tq[$];
    vec_t tbl[$];

    period_detector #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
        .period_out(period_out), .period_valid(period_valid),
        .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // low bits are noise so that only data[7] may matter
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1 data = {lvl, 7'($urandom)};
    endtask

    task automatic run(input int n, input logic strobe, input logic [CNT_W-1:0] per, input logic lck);
        exp_t x;
        repeat (n - 1) tick();
        lvl = ~lvl;
        data = {lvl, 7'($urandom)};
        if (strobe) begin
            x.cyc = cyc + 1; x.per = per; x.lck = lck;
            sq.push_back(x);
        end
        tick();
    endtask

    task automatic add(input int n, input logic s, input int p, input logic l);
        vec_t v;
        v.n = n; v.strobe = s; v.per = CNT_W'(p); v.lck = l;
        tbl.push_back(v);
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            if (sq.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                e = sq.pop_front();
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
                check("period_out", 64'(period_out), 64'(e.per));
                check("locked", 64'(locked), 64'(e.lck));
            end
        end
        if (timeout) begin
            if (tq.size() == 0) check("unexpected_timeout", 1, 0);
            else begin
                tc = tq.pop_front();
                check("timeout_cycle", 64'(cyc), 64'(tc));
            end
        end
    end

    initial begin
        add(10, 0, 0, 0); add(10, 1, 9, 0); add(10, 1, 9, 1); add(10, 1, 9, 1);
        add(7, 1, 6, 0);  add(7, 1, 6, 1);
        add(1, 1, 0, 0);  add(1, 1, 0, 1);  add(1, 1, 0, 1);
        add(4, 1, 3, 0);  add(4, 1, 3, 1);
        #1;
        check("rst_period", 64'(period_out), 0);
        check("rst_valid", 64'(period_valid), 0);
        check("rst_locked", 64'(locked), 0);
        check("rst_timeout", 64'(timeout), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        foreach (tbl[i]) run(tbl[i].n, tbl[i].strobe, tbl[i].per, tbl[i].lck);
        // hold level: MEASURE timeout, then a SYNC timeout 65 cycles later
        tq.push_back(cyc + TMO);
        tq.push_back(cyc + 2 * TMO + 1);
        repeat (135) tick();
        check("tmo_locked", 64'(locked), 0);
        check("tmo_period_held", 64'(period_out), 3);
        run(1, 0, 0, 0);
        run(5, 1, 4, 0);
        run(5, 1, 4, 1);
        run(64, 1, 63, 0);
        run(64, 1, 63, 1);
        run(2, 1, 1, 0);
        run(3, 1, 2, 0);
        run(3, 1, 2, 1);
        // enable drop on an edge cycle
        repeat (2) tick();
        lvl = ~lvl;
        data = {lvl, 7'($urandom)};
        enable = 1'b0;
        tick();
        check("drop_locked", 64'(locked), 0);
        check("drop_period", 64'(period_out), 2);
        lvl = 1'b1;
        data = 8'hFF;
        repeat (3) tick();
        enable = 1'b1;
        repeat (6) tick();
        run(1, 0, 0, 0);
        run(6, 1, 5, 0);
        run(6, 1, 5, 1);
        // async reset with counter at 5
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_period", 64'(period_out), 0);
        check("mid_rst_valid", 64'(period_valid), 0);
        check("mid_rst_locked", 64'(locked), 0);
        check("mid_rst_timeout", 64'(timeout), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        run(1, 0, 0, 0);
        run(8, 1, 7, 0);
        run(8, 1, 7, 1);
        repeat (5) tick();
        check("strobes_pending", 64'(sq.size()), 0);
        check("timeouts_pending", 64'(tq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/period_detector.md
PERIOD_DETECTOR -- requirements
Module: period_detector

Interface
REQ-001 Parameter CNT_W, default 32: counter and result width; matches the oscillator count_max width.
REQ-002 Parameter TIMEOUT, default 1000000: cycles without an edge before the measurement is abandoned; legal range 2 .. 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  measurement enable; low forces IDLE.
REQ-006 data  input  8  pulse-waveform sample, synchronous to clk; only data[7] is used (threshold 0x80).
REQ-007 period_out  output  CNT_W  last measured half-period minus one, i.e. the recovered count_max.
REQ-008 period_valid  output  1  one-cycle strobe: period_out updated this cycle.
REQ-009 locked  output  1  high while the last two measurements were equal.
REQ-010 timeout  output  1  one-cycle strobe: no edge for TIMEOUT cycles.

Function
REQ-011 The block SHALL register data[7] every cycle into lvl_q, in every state including IDLE, so that enabling never creates a false edge.
REQ-012 An edge SHALL be the condition data[7] != lvl_q at a rising clk; both polarities count.
REQ-013 States SHALL be IDLE, SYNC, MEASURE; all outputs registered.
REQ-014 IDLE: counter = 0, locked = 0, no strobes; enable high -> SYNC next cycle.
REQ-015 SYNC: wait for first edge; on edge -> MEASURE with counter <= 1; no period_valid.
REQ-016 SYNC: counter increments saturating; reaching TIMEOUT -> timeout strobe, counter <= 0, stay in SYNC.
REQ-017 MEASURE, no edge: counter <= counter + 1.
REQ-018 MEASURE, edge: period_out <= counter - 1, period_valid <= 1, counter <= 1; state stays MEASURE.
REQ-019 With the oscillator toggling every M = count_max+1 cycles, period_out SHALL equal count_max, valid on the cycle after the edge's sampling clock.
REQ-020 locked SHALL be set on a measurement equal to the previous one and cleared on a differing one, in the same cycle as period_valid.
REQ-021 MEASURE: when counter reaches TIMEOUT with no edge, timeout <= 1 for one cycle, locked <= 0, counter <= 0, state -> SYNC; period_out held.
REQ-022 An edge in the same cycle as counter == TIMEOUT SHALL be treated as an edge (measurement taken, no timeout).
REQ-023 enable low in any state SHALL go to IDLE next cycle, overriding a simultaneous edge or timeout; period_out retained.
REQ-024 counter SHALL never wrap; arithmetic is CNT_W bits unsigned; minimum measurable period_out is 0 (edge every cycle).
REQ-025 The first measurement after SYNC SHALL compare against the retained previous period_out for locked.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, lvl_q 0, period_out 0, period_valid 0, locked 0, timeout 0.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; no strobe on reset release.
REQ-028 Reset release SHALL be followed by normal operation from IDLE on the next clk.

Verification
REQ-029 enable=1, data toggling 0x00/0xFF every 10 cycles -> period_valid every 10 cycles, period_out = 9, locked high from the second strobe.
REQ-030 toggle interval changes 10 -> 7 -> 7 -> period_out 9, 6, 6; locked low at the first 6, high at the second.
REQ-031 TIMEOUT=64, data held at 0xFF after lock -> single timeout strobe 64 cycles after last edge, locked 0, period_out held, next edge gives no strobe, following edge measures.
REQ-032 data toggling every cycle -> period_out = 0 each cycle, period_valid continuously high, locked high.
REQ-033 enable dropped on an edge cycle, then raised with data already 0xFF -> no strobe on drop, no false edge on raise, state SYNC.
REQ-034 rst_n pulsed low mid-MEASURE with counter = 5 -> all outputs 0 asynchronously; first strobe after release only after SYNC plus a full interval.
